// File: rtl/toggle_bank_ctrl_pkg.sv
// rtl/toggle_bank_ctrl_pkg.sv - command opcodes and FSM state encoding for the toggle bank controller
package toggle_bank_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_CLEAR  = 2'b00,
      OP_TOGGLE = 2'b01,
      OP_COUNT  = 2'b10,
      OP_NOP    = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_APPLY = 2'b01,
      ST_COUNT = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

endpackage

// File: rtl/toggle_bank_ctrl_t_ff.sv
// rtl/toggle_bank_ctrl_t_ff.sv - single T flip-flop with synchronous active-high reset
module t_ff (
   input  logic clk,
   input  logic reset,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= 1'b0;
      else if (t)
         q <= ~q;
   end

endmodule

// File: rtl/toggle_bank_ctrl.sv
// rtl/toggle_bank_ctrl.sv - command FSM driving a bank of T flip-flops (clear, toggle mask, count)
module toggle_bank_ctrl
   import toggle_bank_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   state_e           state, state_next;
   op_e              op_r;
   logic [WIDTH-1:0] arg_r;
   logic [WIDTH-1:0] steps;
   logic [WIDTH-1:0] t;
   logic             accept;

   assign accept = cmd_valid && cmd_ready;

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               unique case (op_e'(cmd_op))
                  OP_CLEAR, OP_TOGGLE: state_next = ST_APPLY;
                  OP_COUNT:            state_next = (cmd_arg == '0) ? ST_DONE : ST_COUNT;
                  OP_NOP:              state_next = ST_DONE;
                  default:             state_next = ST_DONE;
               endcase
            end
         end
         ST_APPLY: state_next = ST_DONE;
         ST_COUNT: state_next = (steps == WIDTH'(1)) ? ST_DONE : ST_COUNT;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Increment is a ripple of toggle enables: bit i flips when all lower bits are one.
   always_comb begin
      logic carry;
      cmd_ready = (state == ST_IDLE);
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
      t         = '0;
      carry     = 1'b1;
      if (state == ST_APPLY)
         t = (op_r == OP_CLEAR) ? q : arg_r;
      else if (state == ST_COUNT) begin
         for (int i = 0; i < WIDTH; i++) begin
            t[i]  = carry;
            carry = carry & q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_r  <= OP_NOP;
         arg_r <= '0;
         steps <= '0;
         wrap  <= 1'b0;
      end else begin
         wrap <= (state == ST_COUNT) && (&q);
         if (accept) begin
            op_r  <= op_e'(cmd_op);
            arg_r <= cmd_arg;
            if (op_e'(cmd_op) == OP_COUNT)
               steps <= cmd_arg;
         end else if (state == ST_COUNT) begin
            steps <= steps - WIDTH'(1);
         end
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bank
      t_ff u_t_ff (
         .clk   (clk),
         .reset (reset),
         .t     (t[g]),
         .q     (q[g])
      );
   end

endmodule

// File: tb/tb_toggle_bank_ctrl.sv
// tb/tb_toggle_bank_ctrl.sv - directed self-checking bench for toggle_bank_ctrl
module tb_toggle_bank_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_arg;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;
   logic             wrap;

   int checks   = 0;
   int failures = 0;

   toggle_bank_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .q         (q),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command in IDLE and step past the acceptance edge.
   task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] arg);
      check("ready_before_send", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      tick();
      cmd_valid = 1'b0;
      cmd_arg   = 8'h3C;
   endtask

   // APPLY-type command: q updates one edge after acceptance, done in that cycle.
   task automatic apply_cmd(input logic [1:0] op, input logic [WIDTH-1:0] arg,
                            input logic [WIDTH-1:0] q_before, input logic [WIDTH-1:0] q_after);
      send(op, arg);
      check("apply_q_hold", 32'(q), 32'(q_before));
      check("apply_busy", 32'(busy), 32'd1);
      check("apply_done0", 32'(done), 32'd0);
      check("apply_ready0", 32'(cmd_ready), 32'd0);
      tick();
      check("apply_q", 32'(q), 32'(q_after));
      check("apply_done1", 32'(done), 32'd1);
      check("apply_busy_done", 32'(busy), 32'd1);
      check("apply_wrap", 32'(wrap), 32'd0);
      tick();
      check("apply_done_end", 32'(done), 32'd0);
      check("apply_idle_busy", 32'(busy), 32'd0);
      check("apply_idle_ready", 32'(cmd_ready), 32'd1);
   endtask

   logic [WIDTH-1:0] cnt_exp [5];

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b11;
      cmd_arg   = '0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_q", 32'(q), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);

      apply_cmd(2'b01, 8'hA5, 8'h00, 8'hA5);
      apply_cmd(2'b01, 8'hFF, 8'hA5, 8'h5A);
      apply_cmd(2'b00, 8'h77, 8'h5A, 8'h00);
      apply_cmd(2'b01, 8'hFD, 8'h00, 8'hFD);

      // COUNT 5 from FD crosses the all-ones boundary once.
      cnt_exp[0] = 8'hFE; cnt_exp[1] = 8'hFF; cnt_exp[2] = 8'h00;
      cnt_exp[3] = 8'h01; cnt_exp[4] = 8'h02;
      send(2'b10, 8'd5);
      check("cnt_q_hold", 32'(q), 32'hFD);
      check("cnt_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("cnt_q", 32'(q), 32'(cnt_exp[i]));
         check("cnt_wrap", 32'(wrap), 32'(i == 2));
         check("cnt_done", 32'(done), 32'(i == 4));
      end
      tick();
      check("cnt_idle_done", 32'(done), 32'd0);
      check("cnt_idle_wrap", 32'(wrap), 32'd0);
      check("cnt_idle_ready", 32'(cmd_ready), 32'd1);

      // COUNT 0 then NOP: straight to DONE with q untouched.
      send(2'b10, 8'd0);
      check("cnt0_done", 32'(done), 32'd1);
      check("cnt0_q", 32'(q), 32'h02);
      check("cnt0_wrap", 32'(wrap), 32'd0);
      tick();
      check("cnt0_idle", 32'(done), 32'd0);
      send(2'b11, 8'hFF);
      check("nop_done", 32'(done), 32'd1);
      check("nop_q", 32'(q), 32'h02);
      check("nop_wrap", 32'(wrap), 32'd0);
      tick();
      check("nop_idle", 32'(cmd_ready), 32'd1);

      // Abort a long COUNT with reset, colliding with a new command.
      apply_cmd(2'b00, 8'h00, 8'h02, 8'h00);
      send(2'b10, 8'd200);
      for (int i = 0; i < 50; i++) tick();
      check("abort_q50", 32'(q), 32'd50);
      check("abort_busy", 32'(busy), 32'd1);
      reset     = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_arg   = 8'hFF;
      tick();
      reset     = 1'b0;
      cmd_valid = 1'b0;
      check("abort_q", 32'(q), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd1);
      check("abort_busy0", 32'(busy), 32'd0);
      tick();
      check("abort_no_accept", 32'(busy), 32'd0);
      check("abort_no_done", 32'(done), 32'd0);
      apply_cmd(2'b01, 8'h01, 8'h00, 8'h01);

      // cmd_valid held high with changing operands while busy.
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_arg   = 8'd3;
      tick();
      cmd_op = 2'b01;
      for (int i = 0; i < 3; i++) begin
         cmd_arg = 8'hF0 + 8'(i);
         check("hold_ready0", 32'(cmd_ready), 32'd0);
         tick();
         check("hold_q", 32'(q), 32'(i + 2));
      end
      check("hold_done", 32'(done), 32'd1);
      cmd_arg = 8'h80;
      tick();
      check("hold_idle_ready", 32'(cmd_ready), 32'd1);
      check("hold_idle_q", 32'(q), 32'h04);
      cmd_arg = 8'h0F;
      tick();
      cmd_arg = 8'hAA;
      check("hold_accept_busy", 32'(busy), 32'd1);
      check("hold_apply_q", 32'(q), 32'h04);
      tick();
      cmd_valid = 1'b0;
      check("hold_toggle_q", 32'(q), 32'h0B);
      check("hold_toggle_done", 32'(done), 32'd1);
      tick();
      check("hold_end_ready", 32'(cmd_ready), 32'd1);
      check("hold_end_q", 32'(q), 32'h0B);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
